// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard FSM covering load-use, branch flush, multi-cycle mul/div and interrupt entry.
module hazard_ctrl #(
  parameter int MD_CYCLES    = 32,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       MemReadEX,
  input  logic [4:0] rtaddrEX,
  input  logic [4:0] rsaddrID,
  input  logic [4:0] rtaddrID,
  input  logic       BranchTakenEX,
  input  logic       MulDivStartEX,
  input  logic       intterupt,
  output logic       PCWrite,
  output logic       IFIDWrite,
  output logic       IFIDFlush,
  output logic       IDEXFlush,
  output logic       EXStall,
  output logic       MdDone,
  output logic       IntAck,
  output logic       Busy,
  output logic [1:0] StateOut
);
  typedef enum logic [1:0] {RUN = 2'd0, MDWAIT = 2'd1, INTDRAIN = 2'd2, INTENTER = 2'd3} state_t;
  state_t     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [2:0] drain_q, drain_d;
  logic       int_pend_q, int_pend_d;
  logic       int_prev_q;
  logic       int_edge, load_use;
  assign int_edge = intterupt & ~int_prev_q;
  assign load_use = MemReadEX && rtaddrEX != 5'd0 && (rtaddrEX == rsaddrID || rtaddrEX == rtaddrID);
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    drain_d    = drain_q;
    int_pend_d = int_pend_q | int_edge;
    PCWrite    = 1'b1;
    IFIDWrite  = 1'b1;
    IFIDFlush  = 1'b0;
    IDEXFlush  = 1'b0;
    EXStall    = 1'b0;
    MdDone     = 1'b0;
    IntAck     = 1'b0;
    unique case (state_q)
      RUN: begin
        if (int_pend_q) begin
          PCWrite   = 1'b0;
          IFIDWrite = 1'b0;
          IFIDFlush = 1'b1;
          drain_d   = 3'(DRAIN_CYCLES);
          state_d   = INTDRAIN;
        end else if (BranchTakenEX) begin
          IFIDFlush = 1'b1;
          IDEXFlush = 1'b1;
        end else if (MulDivStartEX) begin
          EXStall   = 1'b1;
          PCWrite   = 1'b0;
          IFIDWrite = 1'b0;
          cnt_d     = 6'(MD_CYCLES - 1);
          state_d   = MDWAIT;
        end else if (load_use) begin
          PCWrite   = 1'b0;
          IFIDWrite = 1'b0;
          IDEXFlush = 1'b1;
        end
      end
      MDWAIT: begin
        PCWrite   = 1'b0;
        IFIDWrite = 1'b0;
        EXStall   = cnt_q != 6'd1;
        MdDone    = cnt_q == 6'd1;
        cnt_d     = cnt_q - 6'd1;
        state_d   = cnt_q == 6'd1 ? RUN : MDWAIT;
      end
      INTDRAIN: begin
        PCWrite   = 1'b0;
        IFIDWrite = 1'b0;
        IFIDFlush = 1'b1;
        IDEXFlush = 1'b1;
        drain_d   = drain_q - 3'd1;
        state_d   = drain_q == 3'd1 ? INTENTER : INTDRAIN;
      end
      INTENTER: begin
        IFIDFlush  = 1'b1;
        IDEXFlush  = 1'b1;
        IntAck     = 1'b1;
        int_pend_d = int_edge;
        state_d    = RUN;
      end
    endcase
    // reset forces a flushed, frozen front end regardless of the stored state
    if (reset) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      IFIDFlush = 1'b1;
      IDEXFlush = 1'b1;
      EXStall   = 1'b0;
      MdDone    = 1'b0;
      IntAck    = 1'b0;
    end
  end
  assign Busy     = ~reset & (state_q != RUN);
  assign StateOut = reset ? 2'd0 : state_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      drain_q    <= '0;
      int_pend_q <= 1'b0;
      int_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      drain_q    <= drain_d;
      int_pend_q <= int_pend_d;
      int_prev_q <= intterupt;
    end
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have parameter MD_CYCLES, default 32, giving the total EX-residency cycles of a multiply/divide (legal range 2..63).
REQ-002 The block SHALL have parameter DRAIN_CYCLES, default 2, giving the cycles spent draining EX/MEM/WB before interrupt entry (legal range 1..7).
REQ-003 clk  in  1  the single clock; all state updates occur on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 MemReadEX  in  1  the instruction in EX is a load.
REQ-006 rtaddrEX  in  5  destination register of the load in EX.
REQ-007 rsaddrID, rtaddrID  in  5 each  source registers of the instruction in ID.
REQ-008 BranchTakenEX  in  1  a branch in EX resolved taken.
REQ-009 MulDivStartEX  in  1  the instruction in EX is a multi-cycle multiply/divide.
REQ-010 intterupt  in  1  external interrupt request, level, asynchronous to the pipeline.
REQ-011 PCWrite, IFIDWrite  out  1 each  PC and IF/ID register enables.
REQ-012 IFIDFlush, IDEXFlush  out  1 each  bubble-insert for IF/ID and ID/EX.
REQ-013 EXStall  out  1  freezes ID/EX and holds the EX instruction.
REQ-014 MdDone  out  1  one-cycle pulse that the multiply/divide result is valid.
REQ-015 IntAck  out  1  one-cycle pulse on which PC loads the interrupt vector.
REQ-016 Busy  out  1  the FSM is not in RUN; StateOut  out  2  current state encoding.

Function
REQ-017 The FSM SHALL have states RUN=0, MDWAIT=1, INTDRAIN=2, INTENTER=3.
REQ-018 Default outputs in any cycle SHALL be PCWrite=1, IFIDWrite=1, all other outputs 0, unless a rule below overrides them.
REQ-019 int_pend SHALL set on a rising edge of intterupt (intterupt=1 with registered int_prev=0) in any state, and SHALL clear in INTENTER; a new edge in INTENTER SHALL win and keep int_pend set.
REQ-020 RUN priority SHALL be: int_pend > BranchTakenEX > MulDivStartEX > load-use.
REQ-021 RUN with int_pend: the block SHALL assert PCWrite=0, IFIDWrite=0, IFIDFlush=1, load drain counter with DRAIN_CYCLES, and go to INTDRAIN.
REQ-022 RUN with BranchTakenEX: the block SHALL assert IFIDFlush=1 and IDEXFlush=1, keep PCWrite=1, and stay in RUN.
REQ-023 RUN with MulDivStartEX: the block SHALL assert EXStall=1, PCWrite=0 and IFIDWrite=0, load md counter with MD_CYCLES-1, and go to MDWAIT.
REQ-024 Load-use SHALL be MemReadEX=1, rtaddrEX!=0, and rtaddrEX equal to rsaddrID or rtaddrID; in RUN it SHALL force PCWrite=0, IFIDWrite=0 and IDEXFlush=1 for that cycle with no state change.
REQ-025 In MDWAIT the block SHALL assert PCWrite=0, IFIDWrite=0 and EXStall=(cnt!=1), and decrement cnt each cycle; when cnt==1 it SHALL assert MdDone=1 and go to RUN.
REQ-026 In MDWAIT, MulDivStartEX, BranchTakenEX and load-use SHALL be ignored, and int_pend SHALL be held until RUN.
REQ-027 In INTDRAIN the block SHALL assert PCWrite=0, IFIDWrite=0, IFIDFlush=1 and IDEXFlush=1, and decrement the drain counter; after DRAIN_CYCLES cycles it SHALL go to INTENTER.
REQ-028 In INTENTER the block SHALL assert PCWrite=1, IFIDFlush=1, IDEXFlush=1 and IntAck=1, clear int_pend, and go to RUN.
REQ-029 Busy SHALL equal (state!=RUN), and StateOut SHALL equal the state encoding.
REQ-030 All outputs SHALL be combinational from state, counters and inputs; state, counters, int_pend and int_prev SHALL be registered.

Reset
REQ-031 While reset=1, the outputs SHALL be PCWrite=0, IFIDWrite=0, IFIDFlush=1, IDEXFlush=1, EXStall=0, MdDone=0, IntAck=0, Busy=0, StateOut=0.
REQ-032 On a clock edge with reset=1, the block SHALL set state=RUN and clear cnt, the drain counter, int_pend and int_prev.
REQ-033 Reset asserted mid-MDWAIT or mid-INTDRAIN SHALL abort the sequence, and the first post-reset cycle SHALL be RUN with no MdDone or IntAck pulse.

Verification
REQ-034 Load-use: MemReadEX=1, rtaddrEX=5, rsaddrID=5 -> exactly one cycle of PCWrite=0, IFIDWrite=0, IDEXFlush=1; with rtaddrEX=0 -> no stall.
REQ-035 Multiply/divide: MulDivStartEX pulse with MD_CYCLES=32 -> EXStall high for 31 consecutive cycles, MdDone on cycle 32 (relative to the start cycle), RUN on cycle 33.
REQ-036 Interrupt: intterupt edge in RUN -> 1 entry cycle plus 2 INTDRAIN cycles with PCWrite=0, then IntAck=1 for exactly one cycle, then RUN.
REQ-037 Interrupt during MDWAIT at cycle 10 -> no IntAck until MdDone completes, then the drain sequence; the level held high -> only one IntAck.
REQ-038 Simultaneous events: BranchTakenEX with load-use in the same cycle -> flush only (PCWrite=1); int_pend with BranchTakenEX -> interrupt path.
REQ-039 Reset at MDWAIT cycle 5 -> all REQ-031 values during reset, then StateOut=0 and no MdDone afterwards.
